// File: rtl/logic_ex_pkg.sv
// Shared definitions for the logic-circuit exercise set: standard 2-input
// truth tables and small evaluation helpers.
package logic_ex_pkg;

   // Truth tables indexed by {A,B}: bit 0 = (A=0,B=0) ... bit 3 = (A=1,B=1)
   localparam logic [3:0] FT_XOR  = 4'b0110;
   localparam logic [3:0] FT_AND  = 4'b1000;
   localparam logic [3:0] FT_OR   = 4'b1110;
   localparam logic [3:0] FT_NAND = 4'b0111;

   function automatic logic tt_eval(input logic [3:0] tbl, input logic a, input logic b);
      return tbl[{a, b}];
   endfunction

   function automatic logic [3:0] combo_onehot(input logic a, input logic b);
      return 4'b0001 << {a, b};
   endfunction

endpackage

// File: rtl/tt_lut2.sv
// Combinational 2-input truth-table lookup; A is the MSB of the table index.
module tt_lut2
   import logic_ex_pkg::*;
#(
   parameter logic [3:0] FUNC_TABLE = FT_XOR
) (
   input  logic a,
   input  logic b,
   output logic y
);

   assign y = tt_eval(FUNC_TABLE, a, b);

endmodule

// File: rtl/circuit.sv
// Registered 2-input function evaluator with sticky coverage of which
// input combinations have been accepted since the last reset.
module circuit
   import logic_ex_pkg::*;
#(
   parameter logic [3:0] FUNC_TABLE = FT_XOR,
   parameter logic       RESET_F2   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic       a,
   input  logic       b,
   output logic       f2,
   output logic       out_valid,
   output logic       f2_comb,
   output logic [3:0] seen,
   output logic       all_seen
);

   logic       f2_d;
   logic [3:0] seen_d;

   tt_lut2 #(
      .FUNC_TABLE(FUNC_TABLE)
   ) u_lut (
      .a(a),
      .b(b),
      .y(f2_d)
   );

   assign f2_comb = f2_d;
   // all_seen is derived from the updated vector so it rises on the same
   // edge that records the final missing combination.
   assign seen_d  = seen | combo_onehot(a, b);

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         f2        <= RESET_F2;
         out_valid <= 1'b0;
         seen      <= 4'b0000;
         all_seen  <= 1'b0;
      end else if (in_valid) begin
         f2        <= f2_d;
         out_valid <= 1'b1;
         seen      <= seen_d;
         all_seen  <= &seen_d;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_circuit.sv
// Self-checking bench for circuit: directed scenarios plus random stimulus
// compared against a behavioural model of the evaluator and its coverage.
module tb_circuit;
   import logic_ex_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       a = 1'b0;
   logic       b = 1'b0;

   logic       f2_x, ov_x, f2c_x, all_x;
   logic [3:0] seen_x;
   logic       f2_n, ov_n, f2c_n, all_n;
   logic [3:0] seen_n;

   int n_checks = 0;
   int n_fail   = 0;

   circuit dut_xor (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .f2(f2_x), .out_valid(ov_x), .f2_comb(f2c_x), .seen(seen_x), .all_seen(all_x)
   );

   circuit #(.FUNC_TABLE(FT_AND), .RESET_F2(1'b0)) dut_and (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .f2(f2_n), .out_valid(ov_n), .f2_comb(f2c_n), .seen(seen_n), .all_seen(all_n)
   );

   always #5 clk = ~clk;

   // Reference model state
   int  m_f2_x, m_f2_n, m_ov;
   bit  m_seen [4];

   function automatic int model_f(input int tbl, input int ia, input int ib);
      return (tbl / (1 << (2 * ia + ib))) % 2;
   endfunction

   function automatic int model_seen_vec();
      int v = 0;
      for (int i = 0; i < 4; i++) if (m_seen[i]) v += (1 << i);
      return v;
   endfunction

   function automatic int model_all();
      int cnt = 0;
      for (int i = 0; i < 4; i++) if (m_seen[i]) cnt++;
      return (cnt == 4) ? 1 : 0;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive inputs, check the combinational output,
   // advance the model on the edge, then check registered outputs.
   task automatic cycle(input bit r, input bit v, input bit ia, input bit ib);
      rst = r; in_valid = v; a = ia; b = ib;
      #1;
      check("f2_comb_xor", f2c_x, model_f(6, ia, ib));
      check("f2_comb_and", f2c_n, model_f(8, ia, ib));
      @(posedge clk);
      if (r) begin
         m_f2_x = 0; m_f2_n = 0; m_ov = 0;
         for (int i = 0; i < 4; i++) m_seen[i] = 0;
      end else if (v) begin
         m_f2_x = model_f(6, ia, ib);
         m_f2_n = model_f(8, ia, ib);
         m_ov   = 1;
         m_seen[2 * ia + ib] = 1;
      end else begin
         m_ov = 0;
      end
      #1;
      check("f2_xor",       f2_x,   m_f2_x);
      check("f2_and",       f2_n,   m_f2_n);
      check("out_valid",    ov_x,   m_ov);
      check("out_valid_and", ov_n,  m_ov);
      check("seen",         seen_x, model_seen_vec());
      check("seen_and",     seen_n, model_seen_vec());
      check("all_seen",     all_x,  model_all());
      check("all_seen_and", all_n,  model_all());
   endtask

   initial begin
      m_f2_x = 0; m_f2_n = 0; m_ov = 0;
      for (int i = 0; i < 4; i++) m_seen[i] = 0;
      @(negedge clk);

      // Reset dominates a valid input
      cycle(1, 1, 1, 0);
      cycle(1, 1, 1, 0);
      check("reset_f2", f2_x, 0);
      check("reset_ov", ov_x, 0);
      check("reset_seen", seen_x, 4'b0000);
      check("reset_all", all_x, 0);

      // Exhaustive sweep, back to back
      cycle(0, 1, 0, 0); check("sweep00_f2", f2_x, 0); check("sweep00_and", f2_n, 0);
      cycle(0, 1, 0, 1); check("sweep01_f2", f2_x, 1); check("sweep01_and", f2_n, 0);
      cycle(0, 1, 1, 0); check("sweep10_f2", f2_x, 1); check("sweep10_and", f2_n, 0);
      check("sweep_all_early", all_x, 0);
      cycle(0, 1, 1, 1); check("sweep11_f2", f2_x, 0); check("sweep11_and", f2_n, 1);
      check("sweep_seen", seen_x, 4'b1111);
      check("sweep_all", all_x, 1);

      // Hold with changing inputs
      cycle(0, 0, 0, 1);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 1, 1);
      check("hold_f2", f2_x, 0);
      check("hold_ov", ov_x, 0);
      check("hold_seen", seen_x, 4'b1111);

      // Mid-sweep reset
      cycle(1, 0, 0, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 0, 1);
      cycle(1, 1, 1, 1);
      check("midrst_f2", f2_x, 0);
      check("midrst_ov", ov_x, 0);
      check("midrst_seen", seen_x, 4'b0000);
      cycle(0, 1, 1, 0);
      cycle(0, 1, 1, 1);
      cycle(0, 1, 0, 1);
      check("midrst_all_pending", all_x, 0);
      cycle(0, 1, 0, 0);
      check("midrst_all_done", all_x, 1);

      // Repeats of one combination
      cycle(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1);
      check("repeat_seen", seen_x, 4'b1000);
      check("repeat_all", all_x, 0);

      // Random stimulus with occasional reset
      for (int i = 0; i < 300; i++)
         cycle(($urandom_range(0, 24) == 0), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
